// File: rtl/exe_stage.sv
// exe_stage: execute stage of the 5-stage RV pipeline, directly downstream of ID/EX.
//   - ALU (shifts, add/sub, logic, set-less-than)
//   - beq/bne/jal/jalr resolution with combinational PC redirect
//   - iterative shift-add unsigned multiplier for MUL/MULHU, stalling upstream while busy
//   - owns the EX/MEM pipeline latch
// Ports:
//   clk, rst (async, active-low)         clock and reset
//   en, flush                            downstream advance enable, hazard-unit flush
//   valid_in, pc_in, *_in                ID/EX instruction, control and operands
//   stall_out                            hold PC, IF/ID, ID/EX (comb)
//   redirect, redirect_pc                taken branch/jump and its target (comb)
//   valid_out ... ecall_out              EX/MEM latch contents
module exe_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MUL_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            jal_in,
  input  logic            jalr_in,
  input  logic            beq_in,
  input  logic            bne_in,
  input  logic            mem_to_reg_in,
  input  logic            mem_write_in,
  input  logic            reg_write_in,
  input  logic            ecall_in,
  input  logic            alu_src_in,
  input  logic [3:0]      alu_op_in,
  input  logic [XLEN-1:0] r1_in,
  input  logic [XLEN-1:0] r2_in,
  input  logic [XLEN-1:0] imm_I_S_in,
  input  logic [XLEN-1:0] imm_B_in,
  input  logic [XLEN-1:0] imm_J_in,
  input  logic [4:0]      rd_addr_in,
  output logic            stall_out,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            valid_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] dmem_data_out,
  output logic [4:0]      rd_addr_out,
  output logic            mem_to_reg_out,
  output logic            mem_write_out,
  output logic            reg_write_out,
  output logic            ecall_out
);

  localparam int unsigned CntW = $clog2(MUL_ITERS);

  localparam logic [3:0] OpSll   = 4'd0;
  localparam logic [3:0] OpSra   = 4'd1;
  localparam logic [3:0] OpSrl   = 4'd2;
  localparam logic [3:0] OpMul   = 4'd3;
  localparam logic [3:0] OpMulhu = 4'd4;
  localparam logic [3:0] OpAdd   = 4'd5;
  localparam logic [3:0] OpSub   = 4'd6;
  localparam logic [3:0] OpAnd   = 4'd7;
  localparam logic [3:0] OpOr    = 4'd8;
  localparam logic [3:0] OpXor   = 4'd9;
  localparam logic [3:0] OpNor   = 4'd10;
  localparam logic [3:0] OpSlt   = 4'd11;
  localparam logic [3:0] OpSltu  = 4'd12;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CntW-1:0]   cnt_q;

  // Control of the multiply in flight, retired in StDone.
  logic              mul_hi_q;
  logic [4:0]        mul_rd_q;
  logic              mul_mem_to_reg_q;
  logic              mul_mem_write_q;
  logic              mul_reg_write_q;
  logic              mul_ecall_q;
  logic [XLEN-1:0]   mul_store_q;

  logic [XLEN-1:0]   op_b;
  logic [4:0]        shamt;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   ex_result;
  logic [XLEN-1:0]   jalr_sum;
  logic [2*XLEN-1:0] acc_step;
  logic              is_mul;
  logic              taken;
  logic              idle;
  logic              rd_write;

  assign op_b   = alu_src_in ? imm_I_S_in : r2_in;
  assign shamt  = op_b[4:0];
  assign is_mul = (alu_op_in == OpMul) || (alu_op_in == OpMulhu);
  assign idle   = (state_q == StIdle);

  always_comb begin
    alu_res = '0;
    case (alu_op_in)
      OpSll:   alu_res = r1_in << shamt;
      OpSra:   alu_res = $signed(r1_in) >>> shamt;
      OpSrl:   alu_res = r1_in >> shamt;
      OpAdd:   alu_res = r1_in + op_b;
      OpSub:   alu_res = r1_in - op_b;
      OpAnd:   alu_res = r1_in & op_b;
      OpOr:    alu_res = r1_in | op_b;
      OpXor:   alu_res = r1_in ^ op_b;
      OpNor:   alu_res = ~(r1_in | op_b);
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, ($signed(r1_in) < $signed(op_b))};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, (r1_in < op_b)};
      default: alu_res = '0;
    endcase
  end

  // Link address replaces the ALU result for jumps.
  assign ex_result = (jal_in || jalr_in) ? (pc_in + XLEN'(4)) : alu_res;

  assign taken = jal_in || jalr_in || (beq_in && (r1_in == r2_in)) ||
                 (bne_in && (r1_in != r2_in));

  assign jalr_sum = r1_in + imm_I_S_in;

  always_comb begin
    redirect_pc = pc_in + (imm_B_in << 1);
    if (jalr_in) begin
      redirect_pc = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (jal_in) begin
      redirect_pc = pc_in + (imm_J_in << 1);
    end
  end

  // Outputs are gated by rst so they read 0 the moment reset is pulled, even with a
  // multiply still presented on the ID/EX inputs.
  assign redirect  = rst && idle && valid_in && taken && en && !flush;
  assign stall_out = rst && ((idle && valid_in && is_mul && !flush) || (state_q == StBusy));

  assign acc_step = acc_q + (mplier_q[0] ? ({{XLEN{1'b0}}, mcand_q} << cnt_q) : '0);
  assign rd_write = reg_write_in && (rd_addr_in != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      mcand_q          <= '0;
      mplier_q         <= '0;
      acc_q            <= '0;
      cnt_q            <= '0;
      mul_hi_q         <= 1'b0;
      mul_rd_q         <= '0;
      mul_mem_to_reg_q <= 1'b0;
      mul_mem_write_q  <= 1'b0;
      mul_reg_write_q  <= 1'b0;
      mul_ecall_q      <= 1'b0;
      mul_store_q      <= '0;
      valid_out        <= 1'b0;
      alu_result_out   <= '0;
      dmem_data_out    <= '0;
      rd_addr_out      <= '0;
      mem_to_reg_out   <= 1'b0;
      mem_write_out    <= 1'b0;
      reg_write_out    <= 1'b0;
      ecall_out        <= 1'b0;
    end else if (flush || en) begin
      // Bubble by default; overridden below when something retires.
      valid_out      <= 1'b0;
      alu_result_out <= '0;
      dmem_data_out  <= '0;
      rd_addr_out    <= '0;
      mem_to_reg_out <= 1'b0;
      mem_write_out  <= 1'b0;
      reg_write_out  <= 1'b0;
      ecall_out      <= 1'b0;
      if (flush) begin
        // Flush takes effect even when en is low.
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (valid_in && is_mul) begin
              mcand_q          <= r1_in;
              mplier_q         <= op_b;
              acc_q            <= '0;
              cnt_q            <= '0;
              mul_hi_q         <= (alu_op_in == OpMulhu);
              mul_rd_q         <= rd_addr_in;
              mul_mem_to_reg_q <= mem_to_reg_in;
              mul_mem_write_q  <= mem_write_in;
              mul_reg_write_q  <= rd_write;
              mul_ecall_q      <= ecall_in;
              mul_store_q      <= r2_in;
              state_q          <= StBusy;
            end else if (valid_in) begin
              valid_out      <= 1'b1;
              alu_result_out <= ex_result;
              dmem_data_out  <= r2_in;
              rd_addr_out    <= rd_addr_in;
              mem_to_reg_out <= mem_to_reg_in;
              mem_write_out  <= mem_write_in;
              reg_write_out  <= rd_write;
              ecall_out      <= ecall_in;
            end
          end
          StBusy: begin
            acc_q    <= acc_step;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(MUL_ITERS - 1)) begin
              state_q <= StDone;
            end
          end
          StDone: begin
            valid_out      <= 1'b1;
            alu_result_out <= mul_hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
            dmem_data_out  <= mul_store_q;
            rd_addr_out    <= mul_rd_q;
            mem_to_reg_out <= mul_mem_to_reg_q;
            mem_write_out  <= mul_mem_write_q;
            reg_write_out  <= mul_reg_write_q;
            ecall_out      <= mul_ecall_q;
            state_q        <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic        valid_in;
  logic [31:0] pc_in;
  logic        jal_in, jalr_in, beq_in, bne_in;
  logic        mem_to_reg_in, mem_write_in, reg_write_in, ecall_in, alu_src_in;
  logic [3:0]  alu_op_in;
  logic [31:0] r1_in, r2_in, imm_I_S_in, imm_B_in, imm_J_in;
  logic [4:0]  rd_addr_in;
  logic        stall_out, redirect;
  logic [31:0] redirect_pc;
  logic        valid_out;
  logic [31:0] alu_result_out, dmem_data_out;
  logic [4:0]  rd_addr_out;
  logic        mem_to_reg_out, mem_write_out, reg_write_out, ecall_out;

  int checks = 0;
  int errors = 0;

  exe_stage #(.XLEN(32), .MUL_ITERS(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .flush          (flush),
    .valid_in       (valid_in),
    .pc_in          (pc_in),
    .jal_in         (jal_in),
    .jalr_in        (jalr_in),
    .beq_in         (beq_in),
    .bne_in         (bne_in),
    .mem_to_reg_in  (mem_to_reg_in),
    .mem_write_in   (mem_write_in),
    .reg_write_in   (reg_write_in),
    .ecall_in       (ecall_in),
    .alu_src_in     (alu_src_in),
    .alu_op_in      (alu_op_in),
    .r1_in          (r1_in),
    .r2_in          (r2_in),
    .imm_I_S_in     (imm_I_S_in),
    .imm_B_in       (imm_B_in),
    .imm_J_in       (imm_J_in),
    .rd_addr_in     (rd_addr_in),
    .stall_out      (stall_out),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .valid_out      (valid_out),
    .alu_result_out (alu_result_out),
    .dmem_data_out  (dmem_data_out),
    .rd_addr_out    (rd_addr_out),
    .mem_to_reg_out (mem_to_reg_out),
    .mem_write_out  (mem_write_out),
    .reg_write_out  (reg_write_out),
    .ecall_out      (ecall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    en = 1'b1; flush = 1'b0; valid_in = 1'b0; pc_in = '0;
    jal_in = 1'b0; jalr_in = 1'b0; beq_in = 1'b0; bne_in = 1'b0;
    mem_to_reg_in = 1'b0; mem_write_in = 1'b0; reg_write_in = 1'b0; ecall_in = 1'b0;
    alu_src_in = 1'b0; alu_op_in = 4'd0; r1_in = '0; r2_in = '0;
    imm_I_S_in = '0; imm_B_in = '0; imm_J_in = '0; rd_addr_in = '0;
  endtask

  task automatic test_reset();
    nop();
    rst = 1'b0;
    #3;
    checks++;
    if ({valid_out, alu_result_out, dmem_data_out, rd_addr_out, mem_to_reg_out,
         mem_write_out, reg_write_out, ecall_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b res=%h data=%h rd=%0d ctl=%b%b%b%b want all 0",
               valid_out, alu_result_out, dmem_data_out, rd_addr_out, mem_to_reg_out,
               mem_write_out, reg_write_out, ecall_out);
    end
    checks++;
    if (stall_out !== 1'b0 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: stall=%b redirect=%b want 0 0", stall_out, redirect);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_add();
    nop();
    valid_in = 1'b1; alu_op_in = 4'd5; alu_src_in = 1'b1; r1_in = 32'h10;
    imm_I_S_in = 32'hFFFF_FFFF; rd_addr_in = 5'd5; reg_write_in = 1'b1; r2_in = 32'hABCD;
    tick();
    nop();
    checks++;
    if (alu_result_out !== 32'h0F || valid_out !== 1'b1 || reg_write_out !== 1'b1 ||
        rd_addr_out !== 5'd5 || dmem_data_out !== 32'hABCD) begin
      errors++;
      $display("FAIL add_imm: res=%h v=%b rw=%b rd=%0d data=%h want 0000000f 1 1 5 0000abcd",
               alu_result_out, valid_out, reg_write_out, rd_addr_out, dmem_data_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || reg_write_out !== 1'b0) begin
      errors++;
      $display("FAIL add_bubble: v=%b rw=%b want 0 0", valid_out, reg_write_out);
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops  [12] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11,
                               4'd12, 4'd13, 4'd5};
    logic [31:0] as   [12] = '{32'h1, 32'h8000_0000, 32'h8000_0000, 32'h5, 32'hF0F0_F0F0,
                               32'hF0, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h1,
                               32'h5, 32'h7FFF_FFFF};
    logic [31:0] bs   [12] = '{32'h24, 32'h4, 32'h4, 32'h7, 32'hFF00_FF00, 32'h0F,
                               32'h0F0F_0F0F, 32'h00FF_0000, 32'h1, 32'hFFFF_FFFF, 32'h7,
                               32'h1};
    logic [31:0] exps [12] = '{32'h10, 32'hF800_0000, 32'h0800_0000, 32'hFFFF_FFFE,
                               32'hF000_F000, 32'hFF, 32'hF0F0_0F0F, 32'hFF00_0000, 32'h1,
                               32'h1, 32'h0, 32'h8000_0000};
    // Back-to-back: one op per cycle, result checked the cycle after issue.
    for (int i = 0; i < 12; i++) begin
      nop();
      valid_in = 1'b1; alu_op_in = ops[i]; r1_in = as[i]; r2_in = bs[i];
      rd_addr_in = 5'(i + 1); reg_write_in = 1'b1;
      tick();
      checks++;
      if (alu_result_out !== exps[i] || valid_out !== 1'b1 || rd_addr_out !== 5'(i + 1)) begin
        errors++;
        $display("FAIL alu_op%0d: res=%h v=%b rd=%0d want %h 1 %0d", ops[i], alu_result_out,
                 valid_out, rd_addr_out, exps[i], i + 1);
      end
    end
    // rd = x0 suppresses the write; other control passes through.
    nop();
    valid_in = 1'b1; alu_op_in = 4'd5; r1_in = 32'h3; r2_in = 32'h4; rd_addr_in = 5'd0;
    reg_write_in = 1'b1; ecall_in = 1'b1; mem_write_in = 1'b1; mem_to_reg_in = 1'b1;
    tick();
    checks++;
    if (reg_write_out !== 1'b0 || ecall_out !== 1'b1 || mem_write_out !== 1'b1 ||
        mem_to_reg_out !== 1'b1 || alu_result_out !== 32'h7) begin
      errors++;
      $display("FAIL rd0_ctl: rw=%b ec=%b mw=%b m2r=%b res=%h want 0 1 1 1 00000007",
               reg_write_out, ecall_out, mem_write_out, mem_to_reg_out, alu_result_out);
    end
    nop();
  endtask

  task automatic test_hold_flush();
    nop();
    valid_in = 1'b1; alu_op_in = 4'd5; r1_in = 32'h100; r2_in = 32'h23; rd_addr_in = 5'd9;
    reg_write_in = 1'b1;
    tick();
    r1_in = 32'h999; en = 1'b0;
    tick();
    checks++;
    if (alu_result_out !== 32'h123 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL en_hold: res=%h v=%b want 00000123 1", alu_result_out, valid_out);
    end
    flush = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0 || reg_write_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_en0: v=%b rw=%b want 0 0", valid_out, reg_write_out);
    end
    nop();
  endtask

  task automatic test_branch();
    nop();
    valid_in = 1'b1; beq_in = 1'b1; pc_in = 32'h100; r1_in = 32'd7; r2_in = 32'd7;
    imm_B_in = 32'h8;
    #1;
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h110) begin
      errors++;
      $display("FAIL beq_taken: redir=%b pc=%h want 1 00000110", redirect, redirect_pc);
    end
    bne_in = 1'b1; beq_in = 1'b0;
    #1;
    checks++;
    if (redirect !== 1'b0) begin
      errors++;
      $display("FAIL bne_equal: redir=%b want 0", redirect);
    end
    r2_in = 32'd8; imm_B_in = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'hF8) begin
      errors++;
      $display("FAIL bne_taken_back: redir=%b pc=%h want 1 000000f8", redirect, redirect_pc);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (redirect !== 1'b0) begin
      errors++;
      $display("FAIL branch_flush: redir=%b want 0", redirect);
    end
    flush = 1'b0; en = 1'b0;
    #1;
    checks++;
    if (redirect !== 1'b0) begin
      errors++;
      $display("FAIL branch_en0: redir=%b want 0", redirect);
    end
    tick();
    nop();
    valid_in = 1'b1; jal_in = 1'b1; pc_in = 32'h100; imm_J_in = 32'h10; alu_op_in = 4'd6;
    #1;
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h120) begin
      errors++;
      $display("FAIL jal_target: redir=%b pc=%h want 1 00000120", redirect, redirect_pc);
    end
    tick();
    nop();
    valid_in = 1'b1; jalr_in = 1'b1; pc_in = 32'h300; r1_in = 32'h201; imm_I_S_in = 32'h0;
    rd_addr_in = 5'd1; reg_write_in = 1'b1; alu_op_in = 4'd5;
    #1;
    checks++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h200) begin
      errors++;
      $display("FAIL jalr_target: redir=%b pc=%h want 1 00000200", redirect, redirect_pc);
    end
    tick();
    nop();
    checks++;
    if (alu_result_out !== 32'h304 || valid_out !== 1'b1 || reg_write_out !== 1'b1) begin
      errors++;
      $display("FAIL jalr_link: res=%h v=%b rw=%b want 00000304 1 1", alu_result_out,
               valid_out, reg_write_out);
    end
  endtask

  task automatic run_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_stall, input int gap_start,
                         input int gap_len);
    int cnt;
    nop();
    valid_in = 1'b1; alu_op_in = op; r1_in = a; r2_in = b; rd_addr_in = 5'd7;
    reg_write_in = 1'b1;
    #1;
    cnt = 0;
    while (stall_out === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
      en = !(gap_len != 0 && cnt >= gap_start && cnt < gap_start + gap_len);
      #1;
    end
    checks++;
    if (cnt !== exp_stall) begin
      errors++;
      $display("FAIL mul%0d_stall_len: cycles=%0d want %0d", op, cnt, exp_stall);
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL mul%0d_early_valid: v=%b want 0", op, valid_out);
    end
    tick();
    checks++;
    if (alu_result_out !== exp || valid_out !== 1'b1 || rd_addr_out !== 5'd7 ||
        reg_write_out !== 1'b1) begin
      errors++;
      $display("FAIL mul%0d_result: res=%h v=%b rd=%0d rw=%b want %h 1 7 1", op,
               alu_result_out, valid_out, rd_addr_out, reg_write_out, exp);
    end
    nop();
    tick();
  endtask

  task automatic test_mul();
    run_mul(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 0, 0);
    run_mul(4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, 0);
    run_mul(4'd3, 32'h1234_5678, 32'h100, 32'h3456_7800, 33, 0, 0);
    run_mul(4'd4, 32'h1234_5678, 32'h100, 32'h0000_0012, 33, 0, 0);
  endtask

  task automatic test_mul_en_gap();
    run_mul(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 38, 10, 5);
  endtask

  task automatic test_mul_flush();
    nop();
    valid_in = 1'b1; alu_op_in = 4'd3; r1_in = 32'd3; r2_in = 32'd5; rd_addr_in = 5'd4;
    reg_write_in = 1'b1;
    repeat (10) tick();
    flush = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy_stall: stall=%b want 1", stall_out);
    end
    tick();
    nop();
    #1;
    checks++;
    if (stall_out !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: stall=%b v=%b want 0 0", stall_out, valid_out);
    end
    repeat (35) begin
      tick();
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_retire: v=%b want 0", valid_out);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    nop();
    valid_in = 1'b1; alu_op_in = 4'd3; r1_in = 32'hFFFF_FFFF; r2_in = 32'hFFFF_FFFF;
    rd_addr_in = 5'd3; reg_write_in = 1'b1;
    repeat (6) tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (stall_out !== 1'b0 || redirect !== 1'b0 || valid_out !== 1'b0 ||
        alu_result_out !== 32'h0 || reg_write_out !== 1'b0 || rd_addr_out !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid_mul: stall=%b redir=%b v=%b res=%h rw=%b rd=%0d want all 0",
               stall_out, redirect, valid_out, alu_result_out, reg_write_out, rd_addr_out);
    end
    nop();
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    valid_in = 1'b1; alu_op_in = 4'd5; r1_in = 32'h20; r2_in = 32'h22; rd_addr_in = 5'd6;
    reg_write_in = 1'b1;
    #1;
    checks++;
    if (stall_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_add_stall: stall=%b want 0", stall_out);
    end
    tick();
    nop();
    checks++;
    if (alu_result_out !== 32'h42 || valid_out !== 1'b1 || rd_addr_out !== 5'd6) begin
      errors++;
      $display("FAIL rst_add_after: res=%h v=%b rd=%0d want 00000042 1 6", alu_result_out,
               valid_out, rd_addr_out);
    end
    repeat (40) begin
      tick();
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_retire: v=%b want 0", valid_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_hold_flush();
    test_branch();
    test_mul();
    test_mul_en_gap();
    test_mul_flush();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
